// File: rtl/nonrestoring_divider_if.sv
// rtl/nonrestoring_divider_if.sv - divider handshake/result bundle; div_zero only under DIV_ZERO_FLAG_EN
interface nonrestoring_divider_if #(
   parameter int W = 8
);
   logic         start;
   logic [W-1:0] Data_A;
   logic [W-1:0] Data_B;
   logic         busy;
   logic         done;
   logic [W-1:0] Quotient;
   logic [W-1:0] Remainder;
`ifdef DIV_ZERO_FLAG_EN
   logic         div_zero;
`endif

   modport master (
      output start, Data_A, Data_B,
      input  busy, done, Quotient, Remainder
`ifdef DIV_ZERO_FLAG_EN
      , input div_zero
`endif
   );

   modport slave (
      input  start, Data_A, Data_B,
      output busy, done, Quotient, Remainder
`ifdef DIV_ZERO_FLAG_EN
      , output div_zero
`endif
   );
endinterface

// File: rtl/nonrestoring_divider.sv
// rtl/nonrestoring_divider.sv - sequential unsigned non-restoring divider; DIV_ZERO_FLAG_EN adds zero-divisor fast path
module nonrestoring_divider #(
   parameter int W = 8
) (
   input logic                  clk,
   input logic                  rst,
   nonrestoring_divider_if.slave bus
);
   localparam int CW = $clog2(W);

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic [W:0]    p;
   logic [W-1:0]  a;
   logic [W-1:0]  d;
   logic          busy_r;
   logic          done_r;
   logic [W-1:0]  quo_r;
   logic [W-1:0]  rem_r;
   logic [W+1:0]  shifted;
   logic [W+1:0]  nxt;

   // One extra bit of headroom: 2P+bit can exceed the W+1-bit range before the add/sub
   always_comb begin
      shifted = {p, a[W-1]};
      nxt     = p[W] ? shifted + {2'b00, d} : shifted - {2'b00, d};
   end

`ifdef DIV_ZERO_FLAG_EN
   logic dz_r;
   assign bus.div_zero = dz_r;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         cnt    <= '0;
         p      <= '0;
         a      <= '0;
         d      <= '0;
         busy_r <= 1'b0;
         done_r <= 1'b0;
         quo_r  <= '0;
         rem_r  <= '0;
`ifdef DIV_ZERO_FLAG_EN
         dz_r   <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  a      <= bus.Data_A;
                  d      <= bus.Data_B;
                  p      <= '0;
                  cnt    <= '0;
                  busy_r <= 1'b1;
`ifdef DIV_ZERO_FLAG_EN
                  dz_r   <= (bus.Data_B == '0);
                  if (bus.Data_B == '0) begin
                     quo_r  <= '1;
                     rem_r  <= bus.Data_A;
                     done_r <= 1'b1;
                     state  <= DONE;
                  end else begin
                     state  <= CALC;
                  end
`else
                  state  <= CALC;
`endif
               end
            end
            CALC: begin
               p <= nxt[W:0];
               a <= {a[W-2:0], ~nxt[W+1]};
               if (cnt == CW'(W - 1)) begin
                  cnt   <= '0;
                  state <= FIX;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            FIX: begin
               // Modular W-bit add is exact: the corrected remainder lies in [0, D)
               quo_r  <= a;
               rem_r  <= p[W] ? p[W-1:0] + d : p[W-1:0];
               done_r <= 1'b1;
               state  <= DONE;
            end
            DONE: begin
               done_r <= 1'b0;
               busy_r <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.busy      = busy_r;
   assign bus.done      = done_r;
   assign bus.Quotient  = quo_r;
   assign bus.Remainder = rem_r;
endmodule

// File: tb/tb_nonrestoring_divider.sv
// tb/tb_nonrestoring_divider.sv - scoreboard bench for nonrestoring_divider (W=8)
module tb_nonrestoring_divider;
   localparam int W = 8;

   typedef struct {
      logic [W-1:0] q;
      logic [W-1:0] r;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_err = 0;
   logic [W-1:0] last_q = '0;
   exp_t sb[$];

   nonrestoring_divider_if #(.W(W)) bus ();

   nonrestoring_divider #(.W(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t e;
      if (b == 0) begin
         e.q = '1;
         e.r = a;
      end else begin
         e.q = a / b;
         e.r = a % b;
      end
      return e;
   endfunction

   task automatic pop_check(input string tag);
      exp_t e;
      if (sb.size() == 0) begin
         check({tag, "_sb_empty"}, 32'd1, 32'd0);
      end else begin
         e = sb.pop_front();
         check({tag, "_quotient"}, 32'(bus.Quotient), 32'(e.q));
         check({tag, "_remainder"}, 32'(bus.Remainder), 32'(e.r));
         last_q = e.q;
      end
   endtask

   task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b);
      int lat;
      int busy_cyc;
      int exp_lat;
      exp_lat = W + 2;
`ifdef DIV_ZERO_FLAG_EN
      if (b == 0) exp_lat = 1;
`endif
      @(negedge clk);
      bus.start  = 1'b1;
      bus.Data_A = a;
      bus.Data_B = b;
      sb.push_back(model(a, b));
      @(posedge clk);
      #1;
      bus.start  = 1'b0;
      bus.Data_A = W'($urandom);
      bus.Data_B = W'($urandom);
      lat      = 1;
      busy_cyc = 0;
      forever begin
         if (bus.busy) busy_cyc++;
         if (bus.done || lat >= 40) break;
         if (lat == 3) check("hold_quotient", 32'(bus.Quotient), 32'(last_q));
         @(posedge clk);
         #1;
         lat++;
      end
      check("latency", lat, exp_lat);
      check("busy_cycles", busy_cyc, exp_lat);
      pop_check("op");
`ifdef DIV_ZERO_FLAG_EN
      check("div_zero", 32'(bus.div_zero), 32'(b == 0));
`endif
      @(posedge clk);
      #1;
      check("idle_busy", 32'(bus.busy), 32'd0);
      check("idle_done", 32'(bus.done), 32'd0);
`ifdef DIV_ZERO_FLAG_EN
      check("div_zero_hold", 32'(bus.div_zero), 32'(b == 0));
`endif
   endtask

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int dones;
      int done_cyc;

      // start held high during reset must be overridden
      bus.start  = 1'b1;
      bus.Data_A = 8'd50;
      bus.Data_B = 8'd5;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_done", 32'(bus.done), 32'd0);
      check("rst_quotient", 32'(bus.Quotient), 32'd0);
      check("rst_remainder", 32'(bus.Remainder), 32'd0);
`ifdef DIV_ZERO_FLAG_EN
      check("rst_div_zero", 32'(bus.div_zero), 32'd0);
`endif
      @(negedge clk);
      bus.start = 1'b0;
      rst       = 1'b0;

      do_op(8'd100, 8'd7);
      do_op(8'd255, 8'd1);
      do_op(8'd5, 8'd10);
      do_op(8'd255, 8'd255);
      do_op(8'd0, 8'd1);

      // starts in cycle 3 and in the done cycle (10) must be ignored
      dones    = 0;
      done_cyc = -1;
      for (int c = 0; c < 16; c++) begin
         @(negedge clk);
         bus.start  = (c == 0 || c == 3 || c == 10);
         bus.Data_A = (c == 0) ? 8'd100 : 8'd9;
         bus.Data_B = (c == 0) ? 8'd7 : 8'd3;
         if (c == 0) sb.push_back(model(8'd100, 8'd7));
         @(posedge clk);
         #1;
         if (bus.done) begin
            dones++;
            done_cyc = c + 1;
            pop_check("busy_ignore");
         end
      end
      bus.start = 1'b0;
      check("ignore_done_count", dones, 1);
      check("ignore_done_cycle", done_cyc, W + 2);
      check("ignore_hold_q", 32'(bus.Quotient), 32'd14);
      check("ignore_hold_r", 32'(bus.Remainder), 32'd2);
      do_op(8'd9, 8'd3);

      // reset in cycle 5 of 200/9 aborts without a done pulse
      dones = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         bus.start  = (c == 0);
         bus.Data_A = 8'd200;
         bus.Data_B = 8'd9;
         rst        = (c == 5);
         @(posedge clk);
         #1;
         if (bus.done) dones++;
      end
      check("abort_busy", 32'(bus.busy), 32'd0);
      check("abort_quotient", 32'(bus.Quotient), 32'd0);
      check("abort_remainder", 32'(bus.Remainder), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 12; c++) begin
         @(posedge clk);
         #1;
         if (bus.done) dones++;
      end
      check("abort_no_done", dones, 0);
      last_q = '0;
      do_op(8'd200, 8'd9);

      do_op(8'd42, 8'd0);
      do_op(8'd13, 8'd4);

      for (int i = 0; i < 2000; i++) begin
         logic [W-1:0] ra;
         logic [W-1:0] rb;
         ra = W'($urandom);
         rb = W'($urandom_range(1, (1 << W) - 1));
         do_op(ra, rb);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
